// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS program/data boot loader.
package mips_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    GAP,
    RUN
  } state_e;

  localparam int unsigned TGT_ICACHE = 0;
  localparam int unsigned TGT_DCACHE = 1;

endpackage

// File: rtl/mips_loader_addr_ctr.sv
// Per-target auto-incrementing write address; the extra MSB flags an exhausted range.
module mips_loader_addr_ctr #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              exh_o
);

  logic [ADDR_W:0] cnt_q, cnt_d;

  // Once exhausted the counter holds until a reload or clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = {1'b0, ld_addr_i} + (ADDR_W + 1)'(1);
    end else if (inc_i && !cnt_q[ADDR_W]) begin
      cnt_d = cnt_q + (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign addr_o = cnt_q[ADDR_W-1:0];
  assign exh_o  = cnt_q[ADDR_W];

endmodule

// File: rtl/mips_boot_loader.sv
// Steers a valid/ready word stream into per-target memory write ports, then raises start.
module mips_boot_loader
  import mips_loader_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int ADDR_W      = 8,
  parameter  int NUM_TGT     = 2,
  parameter  int START_DELAY = 2,
  localparam int TGT_W       = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic [TGT_W-1:0]   s_tgt,
  input  logic               s_addr_ld,
  input  logic [ADDR_W-1:0]  s_addr,
  input  logic               s_last,
  input  logic               restart,
  output logic [DATA_W-1:0]  wr_data,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [NUM_TGT-1:0] wr_en,
  output logic               start,
  output logic               busy,
  output logic               err
);

  localparam int DLY_W = $clog2(START_DELAY + 1);

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [NUM_TGT-1:0] wr_en_q, wr_en_d;
  logic               err_q, err_d;
  logic               start_q, busy_q;

  logic               accept, tgt_ok, leave_run, cur_exh;
  logic [ADDR_W-1:0]  cur_addr;
  logic [NUM_TGT-1:0] sel, ctr_ld, ctr_inc, exh;
  logic [ADDR_W-1:0]  ctr_addr [NUM_TGT];

  for (genvar g = 0; g < NUM_TGT; g++) begin : g_ctr
    mips_loader_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
      .clk_i     (clk),
      .rst_i     (rst),
      .clr_i     (leave_run),
      .ld_i      (ctr_ld[g]),
      .inc_i     (ctr_inc[g]),
      .ld_addr_i (s_addr),
      .addr_o    (ctr_addr[g]),
      .exh_o     (exh[g])
    );
  end

  // Word decode: target select, write address/strobe and error update.
  always_comb begin
    accept    = s_valid & s_ready;
    tgt_ok    = (32'(s_tgt) < NUM_TGT);
    leave_run = (state_q == RUN) && restart;
    sel       = '0;
    cur_addr  = '0;
    cur_exh   = 1'b0;
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      if (s_tgt == TGT_W'(i)) begin
        sel[i]   = accept;
        cur_addr = ctr_addr[i];
        cur_exh  = exh[i];
      end
    end
    ctr_ld    = s_addr_ld ? sel : '0;
    ctr_inc   = s_addr_ld ? '0 : sel;
    wr_en_d   = (s_addr_ld || !cur_exh) ? sel : '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (|wr_en_d) begin
      wr_addr_d = s_addr_ld ? s_addr : cur_addr;
      wr_data_d = s_data;
    end
    if (leave_run) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q | (accept & ~tgt_ok) | (accept & tgt_ok & ~s_addr_ld & cur_exh);
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = s_last ? GAP : LOAD;
        dly_d   = DLY_W'(START_DELAY);
      end
      LOAD: if (accept && s_last) begin
        state_d = GAP;
        dly_d   = DLY_W'(START_DELAY);
      end
      GAP: begin
        if (dly_q == '0) begin
          state_d = RUN;
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      RUN: if (restart) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dly_q     <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      err_q     <= err_d;
      start_q   <= (state_d == RUN);
      busy_q    <= (state_d == LOAD) || (state_d == GAP);
    end
  end

  always_comb begin
    s_ready = (state_q == IDLE) || (state_q == LOAD);
    wr_data = wr_data_q;
    wr_addr = wr_addr_q;
    wr_en   = wr_en_q;
    start   = start_q;
    busy    = busy_q;
    err     = err_q;
  end

endmodule
